// File: rtl/valid_tracker.sv
// Warm-up tracker: counts strobed samples up to TOP_VAL and raises sticky per-stage flags.
// Optional stall restart is compiled in with `define VALID_TRACKER_GAP_EN.
module valid_tracker #(
    parameter int unsigned               TOP_VAL   = 1,
    parameter int unsigned               N_STAGE   = 1,
    parameter logic [N_STAGE*32-1:0]     STAGE_VAL = {N_STAGE{32'd1}},
    parameter int unsigned               MAX_GAP   = 4,
    localparam int unsigned              CNT_W     = $clog2(TOP_VAL + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               clear,
    output logic               out,
    output logic [N_STAGE-1:0] stage_hit,
    output logic               done_pulse,
    output logic               restart_pulse,
    output logic [CNT_W-1:0]   count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    localparam logic [CNT_W-1:0] TOP_CNT = CNT_W'(TOP_VAL);

    if (TOP_VAL == 0 || N_STAGE == 0 || MAX_GAP == 0) begin : g_param_check
        $error("valid_tracker: TOP_VAL, N_STAGE and MAX_GAP must all be >= 1");
    end

    for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_stage_check
        if (STAGE_VAL[32*gi +: 32] == 32'd0 || STAGE_VAL[32*gi +: 32] > TOP_VAL) begin : g_bad
            $error("valid_tracker: STAGE_VAL entry out of range 1..TOP_VAL");
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= TOP_CNT) ? TOP_CNT : c + CNT_W'(1);
    endfunction

    function automatic logic [N_STAGE-1:0] stage_cmp(input logic [CNT_W-1:0] c);
        logic [N_STAGE-1:0] h;
        h = '0;
        for (int i = 0; i < N_STAGE; i++) begin
            h[i] = (32'(c) >= STAGE_VAL[32*i +: 32]);
        end
        return h;
    endfunction

    logic [1:0]         state;
    logic               accept;
    logic               gap_expire;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [N_STAGE-1:0] hit_nxt;
    logic               top_nxt;

    // Once VALID, further strobes are ignored so the count can never wrap.
    assign accept  = in_valid && (state != VALID);
    assign cnt_nxt = accept ? sat_inc(count) : count;
    assign hit_nxt = stage_cmp(cnt_nxt);
    assign top_nxt = (cnt_nxt == TOP_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            stage_hit  <= '0;
            out        <= 1'b0;
            done_pulse <= 1'b0;
        end else if (clear || gap_expire) begin
            state      <= IDLE;
            count      <= '0;
            stage_hit  <= '0;
            out        <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            count      <= cnt_nxt;
            stage_hit  <= hit_nxt;
            out        <= top_nxt;
            done_pulse <= accept && top_nxt;
            if (top_nxt) begin
                state <= VALID;
            end else if (cnt_nxt != '0) begin
                state <= FILL;
            end else begin
                state <= IDLE;
            end
        end
    end

`ifdef VALID_TRACKER_GAP_EN
    localparam int unsigned      GAP_W    = $clog2(MAX_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

    logic [GAP_W-1:0] gap_cnt;

    // The MAX_GAP-th consecutive idle edge is the one that restarts warm-up.
    assign gap_expire = (state != IDLE) && !in_valid && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt       <= '0;
            restart_pulse <= 1'b0;
        end else begin
            restart_pulse <= gap_expire && !clear;
            if (clear || gap_expire || in_valid || state == IDLE) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end
`else
    assign gap_expire    = 1'b0;
    assign restart_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_valid_tracker.sv
// Scoreboard bench for valid_tracker (TOP_VAL=5, STAGE_VAL={3,2}, MAX_GAP=4).
module tb_valid_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       clear;
    logic       out;
    logic [1:0] stage_hit;
    logic       done_pulse;
    logic       restart_pulse;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         c;
        logic [1:0] sh;
        logic       o;
        logic       d;
        logic       r;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   step_idx = 0;

    valid_tracker #(
        .TOP_VAL  (5),
        .N_STAGE  (2),
        .STAGE_VAL({32'd3, 32'd2}),
        .MAX_GAP  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .clear        (clear),
        .out          (out),
        .stage_hit    (stage_hit),
        .done_pulse   (done_pulse),
        .restart_pulse(restart_pulse),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the values expected after the next edge.
    task automatic step(input logic iv, input logic clr, input int c,
                        input logic [1:0] sh, input logic o, input logic d, input logic r);
        exp_t e;
        @(negedge clk);
        in_valid = iv;
        clear    = clr;
        e.c = c; e.sh = sh; e.o = o; e.d = d; e.r = r; e.idx = step_idx;
        step_idx++;
        exp_q.push_back(e);
    endtask

    function automatic logic [1:0] shx(input int k);
        return {k >= 3, k >= 2};
    endfunction

    // Monitor: compare every presented output cycle against the queued expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count",         e.idx, 32'(count),         32'(e.c));
            chk("stage_hit",     e.idx, 32'(stage_hit),     32'(e.sh));
            chk("out",           e.idx, 32'(out),           32'(e.o));
            chk("done_pulse",    e.idx, 32'(done_pulse),    32'(e.d));
            chk("restart_pulse", e.idx, 32'(restart_pulse), 32'(e.r));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"},   -1, 32'(count),         0);
        chk({tag, "_stage"},   -1, 32'(stage_hit),     0);
        chk({tag, "_out"},     -1, 32'(out),           0);
        chk({tag, "_done"},    -1, 32'(done_pulse),    0);
        chk({tag, "_restart"}, -1, 32'(restart_pulse), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Continuous strobes: stage0 at 2, stage1 at 3, out/done at 5, then saturate.
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(1, 0, 2, 2'b01, 0, 0, 0);
        step(1, 0, 3, 2'b11, 0, 0, 0);
        step(1, 0, 4, 2'b11, 0, 0, 0);
        step(1, 0, 5, 2'b11, 1, 1, 0);
        step(1, 0, 5, 2'b11, 1, 0, 0);
        step(1, 0, 5, 2'b11, 1, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 0);

        // Sparse strobes every third cycle: idle runs stay under MAX_GAP.
        for (int k = 1; k <= 6; k++) begin
            int kk;
            kk = (k > 5) ? 5 : k;
            step(1, 0, kk, shx(kk), kk == 5, k == 5, 0);
            step(0, 0, kk, shx(kk), kk == 5, 0, 0);
            step(0, 0, kk, shx(kk), kk == 5, 0, 0);
        end
        step(0, 1, 0, 2'b00, 0, 0, 0);

`ifdef VALID_TRACKER_GAP_EN
        // Stall in FILL at count 3.
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(1, 0, 2, 2'b01, 0, 0, 0);
        step(1, 0, 3, 2'b11, 0, 0, 0);
        step(0, 0, 3, 2'b11, 0, 0, 0);
        step(0, 0, 3, 2'b11, 0, 0, 0);
        step(0, 0, 3, 2'b11, 0, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0, 1);
        step(0, 0, 0, 2'b00, 0, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0, 0);

        // Stall in VALID.
        for (int k = 1; k <= 5; k++) step(1, 0, k, shx(k), k == 5, k == 5, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 5, 2'b11, 1, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0, 1);
        step(0, 0, 0, 2'b00, 0, 0, 0);

        // Clear on the same edge as gap expiry suppresses restart_pulse.
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(1, 0, 2, 2'b01, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 2, 2'b01, 0, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0, 0);
`else
        // Without the gap feature a long stall in VALID changes nothing.
        for (int k = 1; k <= 5; k++) step(1, 0, k, shx(k), k == 5, k == 5, 0);
        for (int k = 0; k < 100; k++) step(0, 0, 5, 2'b11, 1, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 0);
`endif

        // Clear beats a simultaneous strobe at count 4.
        for (int k = 1; k <= 4; k++) step(1, 0, k, shx(k), 0, 0, 0);
        step(1, 1, 0, 2'b00, 0, 0, 0);
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(1, 0, 2, 2'b01, 0, 0, 0);
        step(1, 0, 3, 2'b11, 0, 0, 0);

        // Asynchronous reset between edges mid-FILL.
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(0, 0, 1, 2'b00, 0, 0, 0);

        // TOP_VAL reached after a restart from reset as well.
        step(1, 0, 2, 2'b01, 0, 0, 0);
        step(1, 0, 3, 2'b11, 0, 0, 0);
        step(1, 0, 4, 2'b11, 0, 0, 0);
        step(1, 0, 5, 2'b11, 1, 1, 0);
        step(0, 0, 5, 2'b11, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/valid_tracker.md
# valid_tracker

Parametrised warm-up tracker for the filter datapath. It counts accepted input samples through a strobe, not a gated clock. It raises one sticky flag per configured stage threshold and a final `out` once `TOP_VAL` samples have been seen. Optionally it restarts warm-up when the input stream stalls too long. It sits beside each filter pipeline and qualifies its output-valid and intermediate-stage enables.

## Interface
- `TOP_VAL`, default 1: samples required before `out` asserts; must be ≥1.
- `N_STAGE`, default 1: number of intermediate thresholds; must be ≥1.
- `STAGE_VAL`, default `{N_STAGE{32'd1}}`: packed N_STAGE×32 vector; entry i is at bits [32i+31:32i]. Each entry must satisfy 1 ≤ value ≤ TOP_VAL.
- `MAX_GAP`, default 4: consecutive idle cycles tolerated before restart; must be ≥1. Used only with the gap feature.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: one accepted sample per high cycle.
- `clear`, input, 1: synchronous restart of warm-up.
- `out`, output, 1: high while count == TOP_VAL.
- `stage_hit`, output, N_STAGE: bit i is high while count ≥ STAGE_VAL[i].
- `done_pulse`, output, 1: one-cycle pulse on the first cycle `out` is high after each warm-up.
- `restart_pulse`, output, 1: one-cycle pulse after a gap-induced restart.
- `count`, output, CNT_W = $clog2(TOP_VAL+1): samples accepted, saturating at TOP_VAL.

## Operation
- States:
  - IDLE: count = 0.
  - FILL: 0 < count < TOP_VAL.
  - VALID: count == TOP_VAL.
- Reset (rst = 0): state IDLE; `count`, `stage_hit`, `out`, `done_pulse`, `restart_pulse` and the gap counter all go to 0.
- IDLE → FILL on an edge with `in_valid` = 1. If TOP_VAL = 1, go directly IDLE → VALID.
- FILL: each edge with `in_valid` = 1 increments `count`. The edge that makes count == TOP_VAL enters VALID.
- VALID: `count` holds at TOP_VAL and `in_valid` is ignored for counting. `out` stays high until clear, restart or reset.
- `stage_hit[i]` and `out` are registered and updated at the same edge as `count`. They are never combinational from `in_valid`.
- `done_pulse` is registered and high for exactly one cycle, the first cycle of VALID.
- `clear` = 1 at an edge sets state IDLE and zeroes all outputs and the gap counter. It has priority over `in_valid`: a sample presented in that cycle is not counted. `clear` does not assert `restart_pulse`.
- Gap logic (feature enabled only):
  - In FILL or VALID, the gap counter increments on each edge with `in_valid` = 0 and resets to 0 on `in_valid` = 1.
  - In IDLE the gap counter holds at 0.
  - If `in_valid` = 0 at an edge while gap counter == MAX_GAP−1: state IDLE, count, stage flags and out cleared, gap counter 0, `restart_pulse` = 1 for the following cycle.
- Simultaneous clear and gap expiry: clear wins and `restart_pulse` stays 0.
- A restart or clear in mid-FILL or in VALID behaves identically to starting from reset, except that `restart_pulse` asserts on a gap restart.
- Gap counter width is $clog2(MAX_GAP+1). Count never wraps.

## Timing
- Latency from the k-th accepted `in_valid` cycle to `count` = k: 1 cycle.
- `out` and `done_pulse` rise one cycle after the TOP_VAL-th accepted sample.
- `stage_hit[i]` rises one cycle after the STAGE_VAL[i]-th accepted sample. When STAGE_VAL[i] == TOP_VAL, it rises together with `out`.
- Clear is visible one cycle after the edge it is sampled at.
- Gap restart is visible in the cycle after the MAX_GAP-th consecutive idle cycle.
- Asynchronous reset clears all outputs immediately, regardless of `clk`.

## Configuration
- `VALID_TRACKER_GAP_EN` defined: gap counter and restart logic are present as described, and `MAX_GAP` is honoured.
- `VALID_TRACKER_GAP_EN` undefined: no gap counter is built and `restart_pulse` is tied to 0. Idle cycles never disturb state; only `clear` or `rst` return to IDLE. `MAX_GAP` is ignored.

## Test plan
- Reset, then with TOP_VAL = 5, N_STAGE = 2, STAGE_VAL = {3,2} and `in_valid` held high:
  - `stage_hit[0]` rises 1 cycle after the 2nd sample.
  - `stage_hit[1]` rises 1 cycle after the 3rd sample.
  - `out` and `done_pulse` rise 1 cycle after the 5th sample.
  - `done_pulse` lasts 1 cycle.
  - `count` stays at 5 thereafter.
- Sparse `in_valid` (every 3rd cycle, MAX_GAP = 4): `count` increments only on strobe cycles and never restarts; `out` rises 1 cycle after the 5th strobe.
- Gap enabled, MAX_GAP = 4: in FILL at count = 3, drop `in_valid` for 4 cycles. Next cycle must show count = 0, `stage_hit` = 0 and `restart_pulse` = 1 for one cycle. Repeat with the stall in VALID and check `out` drops.
- `clear` and `in_valid` both high at count = 4: next cycle shows count = 0, `out` = 0, `restart_pulse` = 0. Asserting `clear` on the same edge as gap expiry also gives `restart_pulse` = 0.
- Assert `rst` asynchronously mid-FILL between clock edges: all outputs are 0 immediately. After release, the first strobe gives count = 1.
- Macro undefined: stall `in_valid` for 100 cycles in VALID. `out` stays 1 and `restart_pulse` stays 0 throughout.
